// File: rtl/clk_divider_fsm.sv
// Divide-by-N generator with a counter and a small IDLE/RUN/PAUSE control FSM.
// Provides a run-time loadable divisor, pause/resume, pulse or ~50% square
// output, and a wrap strobe on the last count of each period.
module clk_divider_fsm #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             q,
    output logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DEFAULT_DIV);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;

    logic [WIDTH-1:0] n_eff;
    logic [WIDTH-1:0] last_cnt;
    logic [WIDTH:0]   half_n;

    // Effective divisor (0 and 1 both mean N=1), last phase, and ceil(N/2).
    always_comb begin
        n_eff    = (div_q == '0) ? ONE : div_q;
        last_cnt = n_eff - ONE;
        half_n   = ({1'b0, n_eff} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    end

    // State, phase counter and divisor register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            div_q   <= DIV_INIT;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

    // Next-state logic: load takes priority over enable.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        if (load) begin
            div_d   = div_in;
            count_d = '0;
            if (en) begin
                state_d = RUN;
            end else begin
                case (state_q)
                    IDLE:    state_d = IDLE;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = PAUSE;
                    default: state_d = IDLE;
                endcase
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = RUN;
                        count_d = '0;
                    end
                end
                RUN: begin
                    if (en) begin
                        // Modulo-N wrap; >= also recovers any out-of-range phase.
                        count_d = (count_q >= last_cnt) ? '0 : count_q + ONE;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (en) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Moore output decode from registered state.
    always_comb begin
        active = (state_q == RUN);
        if (mode) begin
            q = active & ({1'b0, count_q} < half_n);
        end else begin
            q = active & (count_q == '0);
        end
        wrap  = active & (count_q == last_cnt);
        count = count_q;
    end

endmodule
